// File: rtl/recorder_ctrl.sv
// Recorder mode controller: key edges, IDLE/REC/PLAY/PAUSE FSM,
// speed controls and recording-end tracking.
module recorder_ctrl #(
  parameter int AW       = 18,
  parameter int ADDR_MAX = 262143,
  parameter int SPD_MAX  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          key_play,
  input  logic          key_record,
  input  logic          key_stop,
  input  logic          key_faster,
  input  logic          key_slower,
  input  logic          key_method,
  input  logic [AW-1:0] addr_i,
  output logic          play,
  output logic          record,
  output logic [3:0]    slow,
  output logic [3:0]    fast,
  output logic          slowmethod,
  output logic [AW-1:0] rec_end,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REC    = 3'd1,
    S_PLAY   = 3'd2,
    S_RPAUSE = 3'd3,
    S_PPAUSE = 3'd4
  } state_t;

  localparam logic [AW-1:0] AMAX = AW'(ADDR_MAX);
  localparam logic signed [4:0] SPD_HI = 5'(SPD_MAX - 1);
  localparam logic signed [4:0] SPD_LO = -SPD_HI;

  logic [1:0]    rst_q;
  logic          rst_n;
  logic [5:0]    key_in;
  logic [5:0]    key_q;
  logic [5:0]    key_edge;
  logic          ev_stop, ev_rec, ev_play;
  logic          ev_fast, ev_slow, ev_meth;
  logic [AW-1:0] a1_q, a2_q, a3_q, addr_s_q;
  state_t        state_q, state_d;
  logic [AW-1:0] rec_end_q, rec_end_d;
  logic          play_q, record_q;
  logic signed [4:0] spd_q, spd_d;
  logic          meth_q;

  // Reset synchronizer: assert immediately, release on clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_q <= 2'b00;
    else          rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  assign key_in = {key_method, key_slower, key_faster,
                   key_stop, key_record, key_play};
  assign key_edge = key_in & ~key_q;

  // Key history for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= '0;
    else        key_q <= key_in;
  end

  // Only the highest-priority edge acts in a given cycle
  always_comb begin
    ev_stop = 1'b0;
    ev_rec  = 1'b0;
    ev_play = 1'b0;
    ev_fast = 1'b0;
    ev_slow = 1'b0;
    ev_meth = 1'b0;
    if      (key_edge[2]) ev_stop = 1'b1;
    else if (key_edge[1]) ev_rec  = 1'b1;
    else if (key_edge[0]) ev_play = 1'b1;
    else if (key_edge[3]) ev_fast = 1'b1;
    else if (key_edge[4]) ev_slow = 1'b1;
    else if (key_edge[5]) ev_meth = 1'b1;
  end

  // Address synchronizer; accept only a value stable over two stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      addr_s_q <= '0;
    end else begin
      a1_q <= addr_i;
      a2_q <= a1_q;
      a3_q <= a2_q;
      if (a2_q == a3_q) addr_s_q <= a3_q;
    end
  end

  // Next-state and recording-end logic
  always_comb begin
    state_d   = state_q;
    rec_end_d = rec_end_q;
    case (state_q)
      S_IDLE: begin
        if (ev_rec)
          state_d = S_REC;
        else if (ev_play && rec_end_q != '0)
          state_d = S_PLAY;
      end
      S_REC: begin
        rec_end_d = addr_s_q;
        if (ev_stop) begin
          state_d = S_IDLE;
        end else if (addr_s_q == AMAX) begin
          state_d   = S_IDLE;
          rec_end_d = AMAX;
        end else if (ev_rec) begin
          state_d = S_RPAUSE;
        end
      end
      S_RPAUSE: begin
        if (ev_stop)     state_d = S_IDLE;
        else if (ev_rec) state_d = S_REC;
      end
      S_PLAY: begin
        if (ev_stop)                     state_d = S_IDLE;
        else if (ev_play)                state_d = S_PPAUSE;
        else if (addr_s_q >= rec_end_q)  state_d = S_IDLE;
      end
      S_PPAUSE: begin
        if (ev_stop)      state_d = S_IDLE;
        else if (ev_play) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating speed index
  always_comb begin
    spd_d = spd_q;
    if (ev_fast && spd_q < SPD_HI)
      spd_d = spd_q + 5'sd1;
    else if (ev_slow && spd_q > SPD_LO)
      spd_d = spd_q - 5'sd1;
  end

  // State, levels, speed and method registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rec_end_q <= '0;
      play_q    <= 1'b0;
      record_q  <= 1'b0;
      spd_q     <= '0;
      meth_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_end_q <= rec_end_d;
      play_q    <= (state_q == S_PLAY);
      record_q  <= (state_q == S_REC);
      spd_q     <= spd_d;
      if (ev_meth) meth_q <= ~meth_q;
    end
  end

  assign play       = play_q;
  assign record     = record_q;
  assign rec_end    = rec_end_q;
  assign state_o    = state_q;
  assign slowmethod = meth_q;
  assign fast = spd_q[4] ? 4'd1 : 4'(spd_q + 5'sd1);
  assign slow = spd_q[4] ? 4'(5'sd1 - spd_q) : 4'd1;

endmodule

// File: tb/tb_recorder_ctrl.sv
// Directed bench for recorder_ctrl: record/play takes, pauses,
// speed saturation, key priority and asynchronous reset.
module tb_recorder_ctrl;

  logic        clk;
  logic        reset_n;
  logic [5:0]  keys;
  logic [17:0] addr_i;
  logic        play, record, slowmethod;
  logic [3:0]  slow, fast;
  logic [17:0] rec_end;
  logic [2:0]  state_o;

  int tests;
  int fails;

  recorder_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_play   (keys[0]),
    .key_record (keys[1]),
    .key_stop   (keys[2]),
    .key_faster (keys[3]),
    .key_slower (keys[4]),
    .key_method (keys[5]),
    .addr_i     (addr_i),
    .play       (play),
    .record     (record),
    .slow       (slow),
    .fast       (fast),
    .slowmethod (slowmethod),
    .rec_end    (rec_end),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int k);
    keys[k] = 1'b1;
    tick(1);
    keys[k] = 1'b0;
    tick(1);
  endtask

  task automatic ramp(input int from, input int to);
    for (int a = from; a <= to; a++) begin
      addr_i = 18'(a);
      tick(4);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    keys    = '0;
    addr_i  = '0;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(4);

    check("rst_play", 32'(play), 0);
    check("rst_record", 32'(record), 0);
    check("rst_slow", 32'(slow), 1);
    check("rst_fast", 32'(fast), 1);
    check("rst_method", 32'(slowmethod), 0);
    check("rst_recend", 32'(rec_end), 0);
    check("rst_state", 32'(state_o), 0);

    // play refused with no recording
    press(0);
    tick(2);
    check("t1_state", 32'(state_o), 0);
    check("t1_play", 32'(play), 0);

    // record a 0..500 take
    press(1);
    check("t2_state_rec", 32'(state_o), 1);
    check("t2_record_hi", 32'(record), 1);
    ramp(0, 250);
    check("t2_record_mid", 32'(record), 1);
    check("t2_play_mid", 32'(play), 0);
    ramp(251, 500);
    tick(8);
    check("t2_recend_live", 32'(rec_end), 500);
    press(2);
    check("t2_state_idle", 32'(state_o), 0);
    check("t2_record_lo", 32'(record), 0);
    check("t2_recend", 32'(rec_end), 500);

    // play the take back until the end address
    addr_i = '0;
    tick(8);
    press(0);
    check("t3_state_play", 32'(state_o), 2);
    check("t3_play_hi", 32'(play), 1);
    ramp(0, 250);
    check("t3_play_mid", 32'(play), 1);
    check("t3_record_mid", 32'(record), 0);
    ramp(251, 500);
    tick(4);
    check("t3_play_end", 32'(play), 0);
    check("t3_state_end", 32'(state_o), 0);

    // speed saturation
    for (int i = 0; i < 9; i++) press(3);
    check("t4_fast_sat", 32'(fast), 8);
    check("t4_slow_one", 32'(slow), 1);
    for (int i = 0; i < 16; i++) press(4);
    check("t4_slow_sat", 32'(slow), 8);
    check("t4_fast_one", 32'(fast), 1);
    press(5);
    check("t4_method", 32'(slowmethod), 1);

    // stop and record together while playing
    addr_i = '0;
    tick(8);
    press(0);
    check("t5_state_play", 32'(state_o), 2);
    keys[2] = 1'b1;
    keys[1] = 1'b1;
    tick(1);
    check("t5_state_idle", 32'(state_o), 0);
    check("t5_record_a", 32'(record), 0);
    keys[2] = 1'b0;
    keys[1] = 1'b0;
    tick(1);
    check("t5_record_b", 32'(record), 0);
    check("t5_play_lo", 32'(play), 0);
    tick(3);
    check("t5_state_hold", 32'(state_o), 0);
    check("t5_speed_kept", 32'(slow), 8);

    // auto-stop at the last sram word
    press(1);
    check("amax_state_rec", 32'(state_o), 1);
    addr_i = 18'h3FFFF;
    tick(8);
    check("amax_state", 32'(state_o), 0);
    check("amax_recend", 32'(rec_end), 262143);
    check("amax_record", 32'(record), 0);

    // record pause and resume
    addr_i = '0;
    tick(8);
    press(1);
    addr_i = 18'd200;
    tick(8);
    press(1);
    check("rp_state", 32'(state_o), 3);
    check("rp_record", 32'(record), 0);
    addr_i = 18'd210;
    tick(8);
    check("rp_recend_held", 32'(rec_end), 200);
    press(1);
    check("rp_resume", 32'(state_o), 1);
    tick(2);
    check("rp_recend_new", 32'(rec_end), 210);
    press(2);

    // play pause and resume
    addr_i = '0;
    tick(8);
    press(0);
    press(0);
    check("pp_state", 32'(state_o), 4);
    check("pp_play", 32'(play), 0);
    press(0);
    check("pp_resume", 32'(state_o), 2);
    check("pp_play_hi", 32'(play), 1);
    press(2);
    check("pp_stop", 32'(state_o), 0);

    // asynchronous reset in the middle of a recording
    press(1);
    addr_i = 18'd300;
    tick(8);
    check("t6_recend_pre", 32'(rec_end), 300);
    check("t6_record_pre", 32'(record), 1);
    reset_n = 1'b0;
    #2;
    check("t6_record_async", 32'(record), 0);
    check("t6_recend_async", 32'(rec_end), 0);
    check("t6_state_async", 32'(state_o), 0);
    check("t6_slow_async", 32'(slow), 1);
    tick(3);
    reset_n = 1'b1;
    addr_i  = '0;
    tick(4);
    press(0);
    tick(2);
    check("t6_play_refused", 32'(state_o), 0);
    check("t6_play_lo", 32'(play), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
